// File: rtl/tlb_unit_pkg.sv
// Shared types for the 32-entry MIPS32 joint TLB.
// Op codes, field positions and the entry layout.
package tlb_unit_pkg;

  localparam int TLB_ENTRIES = 32;
  localparam int IDX_W       = 5;

  localparam int HI_VPN2_LSB = 13;
  localparam int PM_MASK_LSB = 13;
  localparam int LO_PFN_LSB  = 6;

  typedef enum logic [2:0] {
    TLB_OP_NONE  = 3'b000,
    TLB_OP_TLBP  = 3'b001,
    TLB_OP_TLBR  = 3'b010,
    TLB_OP_TLBWI = 3'b011,
    TLB_OP_TLBWR = 3'b100
  } tlb_op_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
  } tlb_key_t;

  typedef struct packed {
    tlb_key_t    key;
    logic [11:0] mask;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic tlb_entry_t mk_entry(
    input logic [31:0] hi,
    input logic [31:0] pm,
    input logic [31:0] lo0,
    input logic [31:0] lo1
  );
    tlb_entry_t e;
    e.key.vpn2 = hi[31:HI_VPN2_LSB];
    e.key.asid = hi[7:0];
    e.key.g    = lo0[0] & lo1[0];
    e.mask     = pm[PM_MASK_LSB+11:PM_MASK_LSB];
    e.pfn0     = lo0[LO_PFN_LSB+19:LO_PFN_LSB];
    e.c0       = lo0[5:3];
    e.d0       = lo0[2];
    e.v0       = lo0[1];
    e.pfn1     = lo1[LO_PFN_LSB+19:LO_PFN_LSB];
    e.c1       = lo1[5:3];
    e.d1       = lo1[2];
    e.v1       = lo1[1];
    return e;
  endfunction

  function automatic logic [31:0] lo_word(
    input logic [19:0] pfn,
    input logic [2:0]  c,
    input logic        d,
    input logic        v,
    input logic        g
  );
    return {6'b0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// Translation request/response bundle for the TLB.
// Requester drives req_*, the TLB answers on rsp_* one cycle later.
interface tlb_unit_if;
  logic        req_valid;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic        rsp_valid;
  logic [31:0] rsp_paddr;
  logic        rsp_uncached;
  logic        rsp_refill;
  logic        rsp_invalid;
  logic        rsp_modified;

  modport master (
    output req_valid, req_vaddr, req_store,
    input  rsp_valid, rsp_paddr, rsp_uncached,
    input  rsp_refill, rsp_invalid, rsp_modified
  );

  modport slave (
    input  req_valid, req_vaddr, req_store,
    output rsp_valid, rsp_paddr, rsp_uncached,
    output rsp_refill, rsp_invalid, rsp_modified
  );
endinterface

// File: rtl/tlb_unit_match.sv
// Fully associative VPN2/ASID search over all TLB keys.
// Reports a hit and the lowest matching index.
module tlb_match
  import tlb_unit_pkg::*;
(
  input  logic [18:0]      vpn2,
  input  logic [7:0]       asid,
  input  tlb_key_t         keys [TLB_ENTRIES],
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan downward so the lowest matching index is the last one kept.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (keys[i].vpn2 == vpn2 &&
          (keys[i].g || keys[i].asid == asid)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// MIPS32 joint TLB: TLBP/TLBR/TLBWI/TLBWR plus one translation per cycle.
// Define TLB_PERF_CNT_EN to add the perf_hit_o/perf_miss_o counters.
module tlb_unit
  import tlb_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  tlb_type_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] cp0_entryhi_i,
  input  logic [31:0] cp0_pagemask_i,
  input  logic [31:0] cp0_entrylo0_i,
  input  logic [31:0] cp0_entrylo1_i,
  input  logic [31:0] cp0_index_i,
  input  logic [31:0] cp0_random_i,
  output logic [31:0] tlb_entryhi_o,
  output logic [31:0] tlb_pagemask_o,
  output logic [31:0] tlb_entrylo0_o,
  output logic [31:0] tlb_entrylo1_o,
  output logic [31:0] tlb_index_o,
`ifdef TLB_PERF_CNT_EN
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o,
`endif
  tlb_unit_if.slave   tr
);

  tlb_entry_t       tlb_q [TLB_ENTRIES];
  tlb_key_t         keys  [TLB_ENTRIES];
  tlb_entry_t       rd_e;
  tlb_entry_t       xe;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             p_hit;
  logic [IDX_W-1:0] p_idx;
  logic             t_hit;
  logic [IDX_W-1:0] t_idx;

  logic        n_mapped;
  logic [31:0] n_paddr;
  logic        n_unc;
  logic        n_ref;
  logic        n_inv;
  logic        n_mod;
  logic [19:0] x_pfn;
  logic [2:0]  x_c;
  logic        x_d;
  logic        x_v;

  always_comb begin
    for (int i = 0; i < TLB_ENTRIES; i++)
      keys[i] = tlb_q[i].key;
  end

  assign wr_en = (tlb_type_i == TLB_OP_TLBWI ||
                  tlb_type_i == TLB_OP_TLBWR) &&
                 !stall_i && !flush_i;
  assign wr_idx = (tlb_type_i == TLB_OP_TLBWR) ?
                  cp0_random_i[IDX_W-1:0] :
                  cp0_index_i[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++)
        tlb_q[i] <= '0;
    end else if (wr_en) begin
      tlb_q[wr_idx] <= mk_entry(cp0_entryhi_i,
        cp0_pagemask_i, cp0_entrylo0_i,
        cp0_entrylo1_i);
    end
  end

  tlb_match u_probe (
    .vpn2 (cp0_entryhi_i[31:HI_VPN2_LSB]),
    .asid (cp0_entryhi_i[7:0]),
    .keys (keys),
    .hit  (p_hit),
    .idx  (p_idx)
  );

  tlb_match u_xlat (
    .vpn2 (tr.req_vaddr[31:HI_VPN2_LSB]),
    .asid (cp0_entryhi_i[7:0]),
    .keys (keys),
    .hit  (t_hit),
    .idx  (t_idx)
  );

  assign tlb_index_o = p_hit ?
    {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;

  assign rd_e = tlb_q[cp0_index_i[IDX_W-1:0]];
  assign tlb_entryhi_o  = {rd_e.key.vpn2, 5'b0,
                           rd_e.key.asid};
  assign tlb_pagemask_o = {7'b0, rd_e.mask, 13'b0};
  assign tlb_entrylo0_o = lo_word(rd_e.pfn0, rd_e.c0,
    rd_e.d0, rd_e.v0, rd_e.key.g);
  assign tlb_entrylo1_o = lo_word(rd_e.pfn1, rd_e.c1,
    rd_e.d1, rd_e.v1, rd_e.key.g);

  assign xe    = tlb_q[t_idx];
  assign x_pfn = tr.req_vaddr[12] ? xe.pfn1 : xe.pfn0;
  assign x_c   = tr.req_vaddr[12] ? xe.c1 : xe.c0;
  assign x_d   = tr.req_vaddr[12] ? xe.d1 : xe.d0;
  assign x_v   = tr.req_vaddr[12] ? xe.v1 : xe.v0;

  // Idle requests produce all-zero fields, so the response is zero when invalid.
  always_comb begin
    n_mapped = 1'b0;
    n_paddr  = '0;
    n_unc    = 1'b0;
    n_ref    = 1'b0;
    n_inv    = 1'b0;
    n_mod    = 1'b0;
    if (tr.req_valid) begin
      if (tr.req_vaddr[31:30] == 2'b10) begin
        n_paddr = {3'b0, tr.req_vaddr[28:0]};
        n_unc   = tr.req_vaddr[29];
      end else begin
        n_mapped = 1'b1;
        if (!t_hit) begin
          n_ref = 1'b1;
        end else begin
          n_paddr = {x_pfn, tr.req_vaddr[11:0]};
          n_unc   = (x_c == 3'd2);
          n_inv   = !x_v;
          n_mod   = x_v && !x_d && tr.req_store;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tr.rsp_valid    <= 1'b0;
      tr.rsp_paddr    <= '0;
      tr.rsp_uncached <= 1'b0;
      tr.rsp_refill   <= 1'b0;
      tr.rsp_invalid  <= 1'b0;
      tr.rsp_modified <= 1'b0;
    end else begin
      tr.rsp_valid    <= tr.req_valid;
      tr.rsp_paddr    <= n_paddr;
      tr.rsp_uncached <= n_unc;
      tr.rsp_refill   <= n_ref;
      tr.rsp_invalid  <= n_inv;
      tr.rsp_modified <= n_mod;
    end
  end

`ifdef TLB_PERF_CNT_EN
  logic mapped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mapped_q    <= 1'b0;
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
    end else begin
      mapped_q <= n_mapped;
      if (tr.rsp_valid && mapped_q) begin
        if (!tr.rsp_refill && !tr.rsp_invalid &&
            !tr.rsp_modified)
          perf_hit_o <= perf_hit_o + 32'd1;
        if (tr.rsp_refill)
          perf_miss_o <= perf_miss_o + 32'd1;
      end
    end
  end
`else
  logic unused_mapped;
  assign unused_mapped = n_mapped;
`endif

  logic unused_bits;
  assign unused_bits = ^{cp0_index_i[31:IDX_W],
    cp0_random_i[31:IDX_W], cp0_pagemask_i[31:25],
    cp0_pagemask_i[12:0], cp0_entryhi_i[12:8],
    cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};

endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: CP0 ops checked inline,
// translations checked by a monitor against a queue of expectations.
module tb_tlb_unit;
  import tlb_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  tlb_type = 3'b000;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi = '0;
  logic [31:0] pm = '0;
  logic [31:0] lo0 = '0;
  logic [31:0] lo1 = '0;
  logic [31:0] ix = '0;
  logic [31:0] rnd = '0;
  logic [31:0] o_hi;
  logic [31:0] o_pm;
  logic [31:0] o_lo0;
  logic [31:0] o_lo1;
  logic [31:0] o_idx;
`ifdef TLB_PERF_CNT_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  tlb_unit_if tr();

  tlb_unit dut (
    .clk            (clk),
    .rst            (rst),
    .tlb_type_i     (tlb_type),
    .stall_i        (stall),
    .flush_i        (flush),
    .cp0_entryhi_i  (hi),
    .cp0_pagemask_i (pm),
    .cp0_entrylo0_i (lo0),
    .cp0_entrylo1_i (lo1),
    .cp0_index_i    (ix),
    .cp0_random_i   (rnd),
    .tlb_entryhi_o  (o_hi),
    .tlb_pagemask_o (o_pm),
    .tlb_entrylo0_o (o_lo0),
    .tlb_entrylo1_o (o_lo1),
    .tlb_index_o    (o_idx),
`ifdef TLB_PERF_CNT_EN
    .perf_hit_o     (perf_hit),
    .perf_miss_o    (perf_miss),
`endif
    .tr             (tr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] pa;
    logic        chk_pa;
    logic [3:0]  fl;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    tr.req_valid = 1'b0;
    tr.req_store = 1'b0;
    tlb_type = 3'b000;
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic setw(input logic [2:0] op, input logic [31:0] i,
                      input logic [31:0] r, input logic [31:0] h,
                      input logic [31:0] p, input logic [31:0] l0,
                      input logic [31:0] l1);
    tlb_type = op;
    ix = i;
    rnd = r;
    hi = h;
    pm = p;
    lo0 = l0;
    lo1 = l1;
  endtask

  // Fields: {uncached, refill, invalid, modified}
  task automatic send(input string n, input logic [31:0] va,
                      input logic st, input logic [31:0] pa,
                      input logic cpa, input logic [3:0] fl);
    exp_t e;
    e.name = n;
    e.pa = pa;
    e.chk_pa = cpa;
    e.fl = fl;
    sbq.push_back(e);
    tr.req_valid = 1'b1;
    tr.req_vaddr = va;
    tr.req_store = st;
  endtask

  task automatic rd(input string n, input logic [31:0] i,
                    input logic [31:0] eh, input logic [31:0] el0,
                    input logic [31:0] el1, input logic [31:0] epm);
    tlb_type = TLB_OP_TLBR;
    ix = i;
    #1;
    chk({n, "_hi"}, o_hi, eh);
    chk({n, "_lo0"}, o_lo0, el0);
    chk({n, "_lo1"}, o_lo1, el1);
    chk({n, "_pm"}, o_pm, epm);
  endtask

  task automatic probe(input string n, input logic [31:0] h,
                       input logic [31:0] ei);
    tlb_type = TLB_OP_TLBP;
    hi = h;
    #1;
    chk(n, o_idx, ei);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tr.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          if (e.chk_pa)
            chk({e.name, "_paddr"}, tr.rsp_paddr, e.pa);
          chk({e.name, "_flags"},
              {28'b0, tr.rsp_uncached, tr.rsp_refill,
               tr.rsp_invalid, tr.rsp_modified},
              {28'b0, e.fl});
        end
      end else if (!rst) begin
        chk("idle_zero",
            {tr.rsp_paddr[31:4],
             tr.rsp_paddr[3:0] | {tr.rsp_uncached,
             tr.rsp_refill, tr.rsp_invalid, tr.rsp_modified}},
            32'd0);
      end
    end
  end

  initial begin : stim
    tr.req_valid = 1'b0;
    tr.req_vaddr = '0;
    tr.req_store = 1'b0;
    step();
    step();
    tr.req_valid = 1'b1;
    tr.req_vaddr = 32'h8000_0000;
    step();
    rst = 1'b0;
    idle();
    chk("rst_discard", {31'b0, tr.rsp_valid}, 32'd0);

    probe("t1_probe_miss", 32'h0040_0005, 32'h8000_0000);
    step();
    idle();

    setw(TLB_OP_TLBWI, 32'd3, 32'd0, 32'h0040_0005, 32'd0,
         32'h0000_1006, 32'h0000_1047);
    step();
    idle();
    rd("t2_rd", 32'd3, 32'h0040_0005, 32'h0000_1006,
       32'h0000_1046, 32'd0);
    step();
    probe("t2_probe_hit", 32'h0040_0005, 32'd3);
    step();
    idle();

    send("t3_ld", 32'h0040_0123, 1'b0, 32'h0004_0123, 1'b1, 4'b0000);
    step();
    send("t3_st_dirty", 32'h0040_0123, 1'b1, 32'h0004_0123, 1'b1,
         4'b0000);
    step();
    idle();
    setw(TLB_OP_TLBWI, 32'd3, 32'd0, 32'h0040_0005, 32'h0001_E000,
         32'h0000_1002, 32'h0000_1041);
    step();
    idle();
    rd("t3_rd", 32'd3, 32'h0040_0005, 32'h0000_1002,
       32'h0000_1040, 32'h0001_E000);
    step();
    idle();
    send("t3_st_mod", 32'h0040_0123, 1'b1, 32'h0004_0123, 1'b1,
         4'b0001);
    step();
    send("t4_inv", 32'h0040_1000, 1'b0, 32'd0, 1'b0, 4'b0010);
    step();
    hi = 32'h0040_0006;
    send("t4_asid_ref", 32'h0040_0123, 1'b0, 32'd0, 1'b0, 4'b0100);
    step();
    hi = 32'h0040_0005;
    send("t5_kseg1", 32'hA000_1000, 1'b0, 32'h0000_1000, 1'b1,
         4'b1000);
    step();
    send("t5_kseg0", 32'h8000_1234, 1'b1, 32'h0000_1234, 1'b1,
         4'b0000);
    step();
    idle();

    setw(TLB_OP_TLBWI, 32'd3, 32'd0, 32'h0080_0005, 32'd0,
         32'h0000_2006, 32'h0000_2006);
    stall = 1'b1;
    step();
    idle();
    setw(TLB_OP_TLBWI, 32'd3, 32'd0, 32'h0080_0005, 32'd0,
         32'h0000_2006, 32'h0000_2006);
    flush = 1'b1;
    step();
    idle();
    rd("t5_rd_kept", 32'd3, 32'h0040_0005, 32'h0000_1002,
       32'h0000_1040, 32'h0001_E000);
    step();
    idle();

    setw(TLB_OP_TLBWR, 32'd0, 32'd7, 32'h00C0_0005, 32'd0,
         32'h0000_3006, 32'h0000_3006);
    send("t6_same_cyc", 32'h00C0_0010, 1'b0, 32'd0, 1'b0, 4'b0100);
    step();
    idle();
    send("t6_next_cyc", 32'h00C0_0010, 1'b0, 32'h000C_0010, 1'b1,
         4'b0000);
    step();
    idle();
    probe("t6_probe_wr", 32'h00C0_0005, 32'd7);
    step();
    idle();

    setw(TLB_OP_TLBWI, 32'h0000_0021, 32'd0, 32'h00C0_0005, 32'd0,
         32'h0000_5016, 32'h0000_5016);
    step();
    idle();
    send("low_idx_unc", 32'h00C0_0010, 1'b0, 32'h0014_0010, 1'b1,
         4'b1000);
    step();
    idle();
    probe("probe_lowest", 32'h00C0_0005, 32'd1);
    step();
    idle();

    setw(TLB_OP_TLBWI, 32'd2, 32'd0, 32'h0100_0005, 32'd0,
         32'h0000_6006, 32'h0000_6006);
    tr.req_valid = 1'b1;
    tr.req_vaddr = 32'h0040_0123;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk("rst_pending", {31'b0, tr.rsp_valid}, 32'd0);
    rd("rst_rd", 32'd1, 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    probe("rst_probe_wr", 32'h0100_0005, 32'h8000_0000);
    step();
    probe("rst_probe_old", 32'h00C0_0005, 32'h8000_0000);
    step();
    idle();

    for (int k = 0; k < 10 && sbq.size() != 0; k++)
      step();
    chk("sb_drain", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
